fp_square: RTL

Iterative unsigned fixed-point squarer: the arithmetic inverse of the `fp_sqrt` primitive, with the same `go`/`done` latency-insensitive handshake so Calyx groups can swap the two. It computes `in*in` in the `INT_WIDTH.FRAC_WIDTH` format, one multiplier bit per cycle using shift-add, with no hard multiplier. The result is truncated toward zero and saturated on overflow. It sits in the math primitive library next to `fp_sqrt`; integer use is `FRAC_WIDTH = 0`.

---
 rtl/fp_square.sv | 95 +++++++++
 1 files changed

// File: rtl/fp_square.sv
// Iterative unsigned fixed-point squarer (INT_WIDTH.FRAC_WIDTH), one shift-add step per cycle.
// Result is truncated toward zero and saturates to all-ones on overflow.
module fp_square #(
  parameter int WIDTH      = 32,
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             done
);

  // Handshake: go is sampled only in IDLE (ignored while BUSY, no queueing);
  // done is a one-cycle pulse and out/overflow hold from that edge until the next done.
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] m, q;
  logic [PW-1:0]    p, p_sum, addend;
  logic             last, ov;
  logic [WIDTH-1:0] res;

  always_comb begin
    addend = q[0] ? ({{WIDTH{1'b0}}, m} << cnt) : '0;
    p_sum  = p + addend;
    last   = (state == BUSY) && (cnt == CW'(WIDTH - 1));
    // Integer bits beyond the result format mean the square does not fit.
    ov     = |p_sum[PW-1:PW-INT_WIDTH];
    res    = ov ? '1 : p_sum[PW-INT_WIDTH-1:FRAC_WIDTH];
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = BUSY;
      BUSY:    if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      m        <= '0;
      q        <= '0;
      p        <= '0;
      out      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            m   <= in;
            q   <= in;
            p   <= '0;
            cnt <= '0;
          end
        end
        BUSY: begin
          p   <= p_sum;
          q   <= q >> 1;
          cnt <= cnt + CW'(1);
          if (last) begin
            out      <= res;
            overflow <= ov;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Golden model: floor(m^2 / 2^FRAC_WIDTH) clamped; m still holds the operand at done.
  logic [PW-1:0]    gold_sq, gold_sh;
  logic [WIDTH-1:0] gold;
  assign gold_sq = {{WIDTH{1'b0}}, m} * {{WIDTH{1'b0}}, m};
  assign gold_sh = gold_sq >> FRAC_WIDTH;
  assign gold    = (|gold_sh[PW-1:WIDTH]) ? '1 : gold_sh[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset && done && (out != gold))
      $error("fp_square self-test: out=%0h golden=%0h", out, gold);
  end

endmodule
